systolic_array_4_4: RTL and testbench
=====================================

Name: systolic_array_4_4

Overview:
- 4x4 weight-stationary systolic array of signed MAC processing elements (PEs), used as the matrix-multiply core of the CNN accelerator.
- Weights are shifted in from the top edge and stored one per PE.
- Activations stream in from the left edge with a row skew; partial sums flow downward.
- Each column's dot product exits at the bottom edge.

Parameters:
- DATA_WIDTH, 32, signed width of weights, activations, partial sums and outputs.

Ports:
- array_clk  in  1  clock, rising edge.
- array_rst_n  in  1  asynchronous active-low reset.
- array_en_left_i_0 (i=0..3)  in  1  activation-valid for row i.
- array_data_left_i_0 (i=0..3)  in  DATA_WIDTH  signed activation for row i.
- array_en_up_0_j (j=0..3)  in  1  weight-load enable for column j.
- array_data_up_0_j (j=0..3)  in  DATA_WIDTH  signed weight entering column j.
- array_en_down_3_j (j=0..3)  out  1  result-valid for column j.
- array_data_down_3_j (j=0..3)  out  DATA_WIDTH  signed column-j result, registered.

Behaviour:
- Reset (async, rst_n=0): all PE weight, activation, partial-sum and valid registers clear to 0. All outputs read 0 until the first MAC reaches row 3.
- PE(i,j) state:
  - w: weight.
  - a_r, a_en_r: activation and its valid, passed right.
  - p_r: partial sum, passed down.
  - v_r: partial-sum valid.
- Weight load, column j, array_en_up_0_j=1:
  - The load enable applies to all four PEs of column j in the same cycle.
  - Each rising edge shifts the column: w(0,j)<=array_data_up_0_j, then w(i,j)<=w(i-1,j) for i=1..3.
  - Four consecutive cycles presenting rows 3,2,1,0 leave w(i,j)=row i value.
  - While loading, column j does no MAC, keeps p_r, and clears v_r and a_en_r.
  - If load and activation are both active in a column, load wins.
- Compute, load inactive:
  - PE(i,j) input activation/valid come from the left port (j=0) or from a_r/a_en_r of PE(i,j-1).
  - Partial-sum input is 0 for i=0, else p_r of PE(i-1,j).
  - Each edge:
    - a_r<=a_in, a_en_r<=en_in.
    - If en_in=1: p_r<=p_in + w*a_in and v_r<=1.
    - Else: p_r holds and v_r<=0.
  - Activations leaving column 3 are discarded.
- Arithmetic: signed multiply-add, truncated to DATA_WIDTH bits (two's-complement wrap, no saturation).
- Outputs: array_data_down_3_j = p_r of PE(3,j); array_en_down_3_j = v_r of PE(3,j).
- Dataflow / skew:
  - Drive row i with element k of its stream at compute cycle k+i.
  - Column j then outputs result k at the edge ending cycle k+3+j, i.e. 4+j cycles after row 0 presents element k.
  - Result: out(k,j) = sum over i of w(i,j)*x_i[k].
  - Zero activations with en=1 contribute 0.
- Weights persist until reloaded.
- Reset mid-operation clears everything immediately, weights included.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all eight outputs 0. Release -> outputs stay 0 with no inputs.
- Weight load: en_up=1 on all columns for 4 cycles with rows [13,14,15,16],[9,10,11,12],[5,6,7,8],[1,2,3,4] -> w(i,j)=4i+j+1. Outputs stay 0 and en_down=0 during the load.
- Skewed compute with those weights: row i streams x_i = B row i, where B = [1,2,3],[4,5,6],[7,8,9],[10,11,12]. Pad with zeros to the skew, en_left=1 throughout.
  - Column 0 emits 214, 242, 270 on consecutive cycles.
  - Column 1 emits 236, 268, 300.
  - Column 2 emits 258, 294, 330.
  - Column 3 emits 280, 320, 360.
  - Each column starts one cycle after the previous one.
- Valid/hold: after compute, drop all en_left -> en_down falls to 0 four-plus cycles later. data_down holds its last value; no further changes.
- Overflow and sign: load w=-1 everywhere and stream 0x7FFFFFFF on row 0 only -> column outputs 0x80000001.
  - Then w=0x40000000 with x=4 on all rows -> the wrapped 32-bit sum equals 0.
- Reset during compute: assert rst_n mid-stream -> outputs and valids go to 0 asynchronously. Weights are cleared, so the next stream yields 0 until a reload.

Source files
------------

// File: rtl/systolic_array_4_4.sv
// 4x4 weight-stationary systolic array of signed MAC PEs.
// Weights shift down from the top, activations move right, partial sums flow down.
module systolic_array_4_4 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  array_clk,
  input  logic                  array_rst_n,
  input  logic                  array_en_left_0_0,
  input  logic                  array_en_left_1_0,
  input  logic                  array_en_left_2_0,
  input  logic                  array_en_left_3_0,
  input  logic [DATA_WIDTH-1:0] array_data_left_0_0,
  input  logic [DATA_WIDTH-1:0] array_data_left_1_0,
  input  logic [DATA_WIDTH-1:0] array_data_left_2_0,
  input  logic [DATA_WIDTH-1:0] array_data_left_3_0,
  input  logic                  array_en_up_0_0,
  input  logic                  array_en_up_0_1,
  input  logic                  array_en_up_0_2,
  input  logic                  array_en_up_0_3,
  input  logic [DATA_WIDTH-1:0] array_data_up_0_0,
  input  logic [DATA_WIDTH-1:0] array_data_up_0_1,
  input  logic [DATA_WIDTH-1:0] array_data_up_0_2,
  input  logic [DATA_WIDTH-1:0] array_data_up_0_3,
  output logic                  array_en_down_3_0,
  output logic                  array_en_down_3_1,
  output logic                  array_en_down_3_2,
  output logic                  array_en_down_3_3,
  output logic [DATA_WIDTH-1:0] array_data_down_3_0,
  output logic [DATA_WIDTH-1:0] array_data_down_3_1,
  output logic [DATA_WIDTH-1:0] array_data_down_3_2,
  output logic [DATA_WIDTH-1:0] array_data_down_3_3
);

  logic                         en_left   [4];
  logic signed [DATA_WIDTH-1:0] data_left [4];
  logic                         en_up     [4];
  logic signed [DATA_WIDTH-1:0] data_up   [4];

  assign en_left   = '{array_en_left_0_0, array_en_left_1_0, array_en_left_2_0, array_en_left_3_0};
  assign data_left = '{array_data_left_0_0, array_data_left_1_0,
                       array_data_left_2_0, array_data_left_3_0};
  assign en_up     = '{array_en_up_0_0, array_en_up_0_1, array_en_up_0_2, array_en_up_0_3};
  assign data_up   = '{array_data_up_0_0, array_data_up_0_1,
                       array_data_up_0_2, array_data_up_0_3};

  // Per-PE state exported as arrays so neighbours can read it.
  logic signed [DATA_WIDTH-1:0] w_arr  [4][4];
  logic signed [DATA_WIDTH-1:0] a_arr  [4][4];
  logic signed [DATA_WIDTH-1:0] p_arr  [4][4];
  logic                         ae_arr [4][4];
  logic                         v_arr  [4][4];

  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      logic signed [DATA_WIDTH-1:0] w_q, a_q, p_q;
      logic                         a_en_q, v_q;
      logic signed [DATA_WIDTH-1:0] a_in, p_in, w_in, mac;
      logic                         en_in;

      if (j == 0) begin : g_edge_left
        assign a_in  = data_left[i];
        assign en_in = en_left[i];
      end else begin : g_inner_left
        assign a_in  = a_arr[i][j-1];
        assign en_in = ae_arr[i][j-1];
      end

      if (i == 0) begin : g_edge_top
        assign p_in = '0;
        assign w_in = data_up[j];
      end else begin : g_inner_top
        assign p_in = p_arr[i-1][j];
        assign w_in = w_arr[i-1][j];
      end

      // Product truncated to DATA_WIDTH: two's-complement wrap.
      assign mac = p_in + w_q * a_in;

      always_ff @(posedge array_clk or negedge array_rst_n) begin
        if (!array_rst_n) begin
          w_q    <= '0;
          a_q    <= '0;
          p_q    <= '0;
          a_en_q <= 1'b0;
          v_q    <= 1'b0;
        end else if (en_up[j]) begin
          // Load has priority: shift weights, freeze the sum, kill valids.
          w_q    <= w_in;
          a_en_q <= 1'b0;
          v_q    <= 1'b0;
        end else begin
          a_q    <= a_in;
          a_en_q <= en_in;
          v_q    <= en_in;
          if (en_in) p_q <= mac;
        end
      end

      assign w_arr[i][j]  = w_q;
      assign a_arr[i][j]  = a_q;
      assign p_arr[i][j]  = p_q;
      assign ae_arr[i][j] = a_en_q;
      assign v_arr[i][j]  = v_q;
    end
  end

  assign array_en_down_3_0   = v_arr[3][0];
  assign array_en_down_3_1   = v_arr[3][1];
  assign array_en_down_3_2   = v_arr[3][2];
  assign array_en_down_3_3   = v_arr[3][3];
  assign array_data_down_3_0 = p_arr[3][0];
  assign array_data_down_3_1 = p_arr[3][1];
  assign array_data_down_3_2 = p_arr[3][2];
  assign array_data_down_3_3 = p_arr[3][3];

endmodule

// File: tb/tb_systolic_array_4_4.sv
// Self-checking bench for systolic_array_4_4: per-column scoreboard queues filled from a
// weight/stream reference model and drained as the array raises its result valids.
module tb_systolic_array_4_4;

  logic        clk;
  logic        rst_n;
  logic        en_left   [4];
  logic [31:0] data_left [4];
  logic        en_up     [4];
  logic [31:0] data_up   [4];
  logic        en_down   [4];
  logic [31:0] data_down [4];

  int unsigned n_tests;
  int unsigned n_fail;

  logic [31:0] w_model  [4][4];
  logic [31:0] stim     [4][8];
  int          stim_len;
  logic [31:0] last_out [4];
  logic [31:0] exp_q    [4][$];

  systolic_array_4_4 #(.DATA_WIDTH(32)) dut (
    .array_clk           (clk),
    .array_rst_n         (rst_n),
    .array_en_left_0_0   (en_left[0]),
    .array_en_left_1_0   (en_left[1]),
    .array_en_left_2_0   (en_left[2]),
    .array_en_left_3_0   (en_left[3]),
    .array_data_left_0_0 (data_left[0]),
    .array_data_left_1_0 (data_left[1]),
    .array_data_left_2_0 (data_left[2]),
    .array_data_left_3_0 (data_left[3]),
    .array_en_up_0_0     (en_up[0]),
    .array_en_up_0_1     (en_up[1]),
    .array_en_up_0_2     (en_up[2]),
    .array_en_up_0_3     (en_up[3]),
    .array_data_up_0_0   (data_up[0]),
    .array_data_up_0_1   (data_up[1]),
    .array_data_up_0_2   (data_up[2]),
    .array_data_up_0_3   (data_up[3]),
    .array_en_down_3_0   (en_down[0]),
    .array_en_down_3_1   (en_down[1]),
    .array_en_down_3_2   (en_down[2]),
    .array_en_down_3_3   (en_down[3]),
    .array_data_down_3_0 (data_down[0]),
    .array_data_down_3_1 (data_down[1]),
    .array_data_down_3_2 (data_down[2]),
    .array_data_down_3_3 (data_down[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      en_left[i]   = 1'b0;
      data_left[i] = '0;
      en_up[i]     = 1'b0;
      data_up[i]   = '0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int j = 0; j < 4; j++) begin
      check_eq($sformatf("%s_en%0d", tag, j), {31'd0, en_down[j]}, 32'd0);
      check_eq($sformatf("%s_data%0d", tag, j), data_down[j], last_out[j]);
    end
  endtask

  function automatic logic [31:0] model_out(input int k, input int j);
    logic signed [63:0] acc;
    acc = 0;
    for (int i = 0; i < 4; i++)
      acc += $signed({{32{w_model[i][j][31]}}, w_model[i][j]}) *
             $signed({{32{stim[i][k][31]}}, stim[i][k]});
    return acc[31:0];
  endfunction

  // Shift rows 3..0 into every column; outputs must stay idle meanwhile.
  task automatic load_weights();
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check_idle_outputs("load");
      for (int j = 0; j < 4; j++) begin
        en_up[j]   = (t < 4);
        data_up[j] = (t < 4) ? w_model[3-t][j] : '0;
      end
    end
  endtask

  // Drive stim with row skew; abort_at >= 0 asserts reset mid-stream at that cycle.
  task automatic run_stream(input string tag, input int abort_at);
    int k;
    int n_cyc;
    logic [31:0] e;
    n_cyc = stim_len + 6 + 5;
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (en_down[j]) begin
          if (exp_q[j].size() == 0) begin
            check_eq($sformatf("%s_extra%0d", tag, j), {31'd0, en_down[j]}, 32'd0);
          end else begin
            e = exp_q[j].pop_front();
            check_eq($sformatf("%s_col%0d", tag, j), data_down[j], e);
            last_out[j] = e;
          end
        end else begin
          check_eq($sformatf("%s_hold%0d", tag, j), data_down[j], last_out[j]);
        end
      end
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
          check_eq($sformatf("%s_rst_en%0d", tag, j), {31'd0, en_down[j]}, 32'd0);
          check_eq($sformatf("%s_rst_data%0d", tag, j), data_down[j], 32'd0);
          exp_q[j].delete();
          last_out[j] = '0;
          for (int i = 0; i < 4; i++) w_model[i][j] = '0;
        end
        idle_inputs();
        return;
      end
      for (int i = 0; i < 4; i++) begin
        k = c - i;
        en_left[i]   = (k >= 0 && k < stim_len);
        data_left[i] = (k >= 0 && k < stim_len) ? stim[i][k] : '0;
      end
      if (c < stim_len)
        for (int j = 0; j < 4; j++) exp_q[j].push_back(model_out(c, j));
    end
    for (int j = 0; j < 4; j++)
      check_eq($sformatf("%s_missing%0d", tag, j), exp_q[j].size(), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    for (int j = 0; j < 4; j++) last_out[j] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset");

    // Weights w(i,j) = 4i+j+1.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w_model[i][j] = 32'(4 * i + j + 1);
    load_weights();

    stim_len = 3;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) stim[i][k] = 32'(3 * i + k + 1);
    run_stream("mm", -1);
    repeat (4) @(negedge clk);
    check_idle_outputs("idle_hold");

    // w = -1, only row 0 carries a non-zero activation.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w_model[i][j] = 32'hFFFF_FFFF;
    load_weights();
    stim_len = 2;
    for (int i = 0; i < 4; i++) begin
      stim[i][0] = (i == 0) ? 32'h7FFF_FFFF : 32'd0;
      stim[i][1] = (i == 0) ? 32'd1 : 32'd0;
    end
    run_stream("neg", -1);

    // Every product wraps to zero.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w_model[i][j] = 32'h4000_0000;
    load_weights();
    stim_len = 1;
    for (int i = 0; i < 4; i++) stim[i][0] = 32'd4;
    run_stream("wrap", -1);

    // Reset mid-stream with non-trivial weights.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w_model[i][j] = 32'(4 * i + j + 1);
    load_weights();
    stim_len = 3;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) stim[i][k] = 32'(3 * i + k + 1);
    run_stream("abort", 5);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_abort");
    run_stream("zero_w", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
